// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake between a requester and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  // Requester side: raises tx_valid with a byte, watches busy/done/err
  modport master (
    output tx_valid,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  tx_err
  );

  // Transmitter side
  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter, open-drain; optional watchdog under PS2_TX_TIMEOUT_EN
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 10000,
  parameter int FILTER_CYC  = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  // One cycle counter times the inhibit phase and, when enabled, the watchdog
  // from REQ entry; it is sized for the longer of the two intervals.
  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST     = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] INH_PRE_LAST = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(FILTER_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_ONE      = FLT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             parity;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             clk_s1;
  logic             clk_s2;
  logic             data_s1;
  logic             data_s2;
  logic             clk_filt;
  logic             clk_filt_d;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall;

  assign host.tx_busy = busy_q;
  assign host.tx_done = done_q;
  assign host.tx_err  = err_q;

  // Bring both pad levels into the clk domain; idle lines read high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  // Accept a new PS2_CLK level only after FILTER_CYC consecutive samples agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s2 != clk_filt) begin
        if (flt_cnt == FLT_LAST) begin
          clk_filt <= clk_s2;
          flt_cnt  <= '0;
        end else begin
          flt_cnt <= flt_cnt + FLT_ONE;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // Transmit sequencer: inhibit, request-to-send, clocked bits, ACK, wait for bus idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (host.tx_valid) begin
            shreg      <= host.tx_data;
            parity     <= ~^host.tx_data;
            busy_q     <= 1'b1;
            ps2_clk_oe <= 1'b1;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= INHIBIT;
          end
        end

        // Clock held low for INHIBIT_CYC cycles; data goes low on the last one
        INHIBIT: begin
          cyc_cnt <= cyc_cnt + CNT_ONE;
          if (cyc_cnt == INH_PRE_LAST) begin
            ps2_data_oe <= 1'b1;
          end
          if (cyc_cnt == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            cyc_cnt     <= '0;
            state       <= REQ;
          end
        end

        // Start bit is on the line; first device fall asks for data bit 0
        REQ: begin
          if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= {1'b0, shreg[7:1]};
            bit_cnt     <= 4'd1;
            state       <= DATA;
          end
        end

        // bit_cnt holds falls seen so far; this fall is number bit_cnt+1
        DATA: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[7:1]};
            end else if (bit_cnt == 4'd8) begin
              ps2_data_oe <= ~parity;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end

        // Device must hold data low across the eleventh fall
        ACK: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (!data_s2) begin
              state <= WAIT_IDLE;
            end else begin
              err_q       <= 1'b1;
              busy_q      <= 1'b0;
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              state       <= IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (clk_filt && data_s2) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides the sequencer once the device has had TIMEOUT_CYC cycles
      if (state inside {REQ, DATA, ACK, WAIT_IDLE}) begin
        cyc_cnt <= cyc_cnt + CNT_ONE;
        if (cyc_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_q       <= 1'b1;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= IDLE;
        end
      end
`else
      // Without the watchdog the sequencer waits on the device indefinitely
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx with a behavioural PS/2 device
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 300;
  localparam int FILT = 4;
  localparam int TO   = 5000;
  localparam int H    = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if hif();

  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line;
  logic ps2_data_line;
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .FILTER_CYC (FILT),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (hif),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic got_bits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count completion pulses; busy must already be low when done is seen
  always @(negedge clk) begin
    if (rst_n) begin
      if (hif.tx_done) begin
        done_cnt++;
        check("busy_low_with_done", hif.tx_busy, 1'b0);
      end
      if (hif.tx_err) err_cnt++;
    end
  end

  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    hif.tx_data  = d;
    hif.tx_valid = 1'b1;
    @(negedge clk);
    hif.tx_valid = 1'b0;
  endtask

  // Follow the inhibit phase; returns at the first REQ cycle
  task automatic watch_inhibit();
    int g;
    int inh;
    logic last_doe;
    g = 0;
    while (ps2_clk_oe !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("inhibit_start", ps2_clk_oe, 1'b1);
    inh = 0;
    last_doe = 1'b0;
    while (ps2_clk_oe === 1'b1 && inh < INH + 50) begin
      last_doe = ps2_data_oe;
      inh++;
      @(negedge clk);
    end
    check("inhibit_len", inh, INH);
    check("data_low_last_inhibit", last_doe, 1'b1);
    check("start_bit", ps2_data_line, 1'b0);
    check("busy_in_req", hif.tx_busy, 1'b1);
  endtask

  // Device model: clocks 11 bits, samples while clock is low, optionally ACKs
  task automatic xfer(input logic [7:0] d, input bit ack, input int rst_fall, input bit inject);
    int d0;
    int e0;
    logic exp_bits[$];
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(d);
    watch_inhibit();
    got_bits = {};
    for (int f = 1; f <= 11; f++) begin
      repeat (H) @(negedge clk);
      if (f == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (4) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (f == rst_fall) begin
        repeat (H / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_busy", hif.tx_busy, 1'b0);
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        return;
      end
      if (inject && f == 3) begin
        hif.tx_data  = 8'hFF;
        hif.tx_valid = 1'b1;
        @(negedge clk);
        hif.tx_valid = 1'b0;
        repeat (H - 2) @(negedge clk);
      end else begin
        repeat (H - 1) @(negedge clk);
      end
      if (f <= 10) got_bits.push_back(ps2_data_line);
      @(negedge clk);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
    repeat (100) @(negedge clk);

    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(~^d);
    exp_bits.push_back(1'b1);
    check("bit_count", got_bits.size(), 10);
    for (int i = 0; i < 10 && i < got_bits.size(); i++)
      check($sformatf("bit%0d_of_%02h", i, d), got_bits[i], exp_bits[i]);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("err_pulses", err_cnt - e0, ack ? 0 : 1);
    check("end_clk_oe", ps2_clk_oe, 1'b0);
    check("end_data_oe", ps2_data_oe, 1'b0);
    check("end_busy", hif.tx_busy, 1'b0);
  endtask

  initial begin
    int cnt;
    int e0;
    hif.tx_valid = 1'b0;
    hif.tx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_clk_oe", ps2_clk_oe, 1'b0);
    check("reset_data_oe", ps2_data_oe, 1'b0);
    check("reset_busy", hif.tx_busy, 1'b0);
    check("reset_done", hif.tx_done, 1'b0);
    check("reset_err", hif.tx_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    xfer(8'hED, 1'b1, 0, 1'b0);
    xfer(8'h02, 1'b1, 0, 1'b0);
    xfer(8'h00, 1'b0, 0, 1'b0);
    xfer(8'h5A, 1'b1, 0, 1'b1);
    xfer(8'h81, 1'b1, 5, 1'b0);
    xfer(8'hC3, 1'b1, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      xfer(8'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    // Silent device after request-to-send
    e0 = err_cnt;
    send_req(8'h3C);
    watch_inhibit();
`ifdef PS2_TX_TIMEOUT_EN
    cnt = 0;
    while (hif.tx_err !== 1'b1 && cnt < TO + 50) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", cnt, TO);
    check("timeout_clk_oe", ps2_clk_oe, 1'b0);
    check("timeout_data_oe", ps2_data_oe, 1'b0);
    check("timeout_busy", hif.tx_busy, 1'b0);
`else
    cnt = 0;
    repeat (TO + 500) @(negedge clk);
    check("no_timeout_busy", hif.tx_busy, 1'b1);
    check("no_timeout_err", err_cnt - e0, cnt);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
